// File: rtl/serial_paralelo_rx_param_if.sv
// Serial receiver bus: serial input side and word output side.
// Master drives the serial stream, slave is the receiver.
interface serial_paralelo_rx_param_if #(
  parameter int WORD_W = 8
);
  logic              data_in;
  logic              resync;
  logic [WORD_W-1:0] data_out;
  logic              valid;
  logic              active;
  logic              idle_out;

  modport master (
    output data_in, resync,
    input  data_out, valid, active, idle_out
  );

  modport slave (
    input  data_in, resync,
    output data_out, valid, active, idle_out
  );
endinterface

// File: rtl/serial_paralelo_rx_param.sv
// Serial-to-parallel receiver with COM-based word alignment.
// Hunts for COM, confirms alignment, then forwards data words.
module serial_paralelo_rx_param #(
  parameter int              WORD_W    = 8,
  parameter logic [WORD_W-1:0] COM_SYM  = 8'hBC,
  parameter logic [WORD_W-1:0] IDLE_SYM = 8'h7C,
  parameter int              COM_COUNT = 4
) (
  input logic clk_32f,
  input logic default_values,
  serial_paralelo_rx_param_if.slave bus
);

  localparam int CW = $clog2(COM_COUNT + 1);
  localparam int BW = $clog2(WORD_W);

  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] ALIGN  = 2'd1;
  localparam logic [1:0] ACTIVE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [WORD_W-1:0] sr_q, sr_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]     com_cnt_q, com_cnt_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              active_q, active_d;
  logic              idle_q, idle_d;

  logic [WORD_W-1:0] word;
  logic              boundary;
  logic [BW-1:0]     bit_nxt;
  logic [CW-1:0]     com_inc;

  assign word     = {sr_q[WORD_W-2:0], bus.data_in};
  assign boundary = (bit_cnt_q == BW'(WORD_W - 1));
  assign bit_nxt  = boundary ? '0 : bit_cnt_q + BW'(1);
  assign com_inc  = com_cnt_q + CW'(1);

  // Next-state: alignment FSM, counters and output word handling
  always_comb begin
    state_d   = state_q;
    sr_d      = word;
    bit_cnt_d = bit_cnt_q;
    com_cnt_d = com_cnt_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    idle_d    = idle_q;
    if (bus.resync) begin
      state_d   = SEARCH;
      bit_cnt_d = '0;
      com_cnt_d = '0;
      idle_d    = 1'b0;
    end else begin
      case (state_q)
        SEARCH: begin
          if (word == COM_SYM) begin
            bit_cnt_d = '0;
            com_cnt_d = CW'(1);
            state_d   = (COM_COUNT == 1) ? ACTIVE : ALIGN;
          end
        end
        ALIGN: begin
          bit_cnt_d = bit_nxt;
          if (boundary) begin
            if (word == COM_SYM) begin
              com_cnt_d = com_inc;
              if (com_inc == CW'(COM_COUNT)) state_d = ACTIVE;
            end else begin
              com_cnt_d = '0;
              state_d   = SEARCH;
            end
          end
        end
        ACTIVE: begin
          bit_cnt_d = bit_nxt;
          if (boundary) begin
            unique case (1'b1)
              (word == COM_SYM):  idle_d = 1'b0;
              (word == IDLE_SYM): idle_d = 1'b1;
              default: begin
                data_d  = word;
                valid_d = 1'b1;
                idle_d  = 1'b0;
              end
            endcase
          end
        end
        default: begin
          state_d   = SEARCH;
          bit_cnt_d = '0;
          com_cnt_d = '0;
        end
      endcase
    end
    active_d = (state_d == ACTIVE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_32f) begin
    if (default_values) begin
      state_q   <= SEARCH;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      com_cnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
      idle_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      com_cnt_q <= com_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      active_q  <= active_d;
      idle_q    <= idle_d;
    end
  end

  assign bus.data_out = data_q;
  assign bus.valid    = valid_q;
  assign bus.active   = active_q;
  assign bus.idle_out = idle_q;

endmodule

// File: doc/serial_paralelo_rx_param.md
# serial_paralelo_rx_param

Parametrised serial-to-parallel receiver for the PHY path: deserialises a one-bit stream sampled on `clk_32f`, acquires word alignment by hunting for a configurable COM symbol, and declares the link active after a programmable number of consecutive aligned COM words. Once active, it forwards data words with a one-cycle valid strobe, flags IDLE words, and drops back to hunting on a resync request or reset. Word width and symbol values are generic, so the same block serves the 8-bit lanes and wider encoded lanes.

## Interface
- `WORD_W`, 8: bits per word; legal range ≥ 2.
- `COM_SYM`, 8'hBC: alignment (COM) symbol, `WORD_W` bits.
- `IDLE_SYM`, 8'h7C: idle symbol, `WORD_W` bits; must differ from `COM_SYM`.
- `COM_COUNT`, 4: consecutive aligned COM words needed to go active; legal range ≥ 1.

Ports:
- `clk_32f`  in  1  bit clock; every rising edge samples one serial bit.
- `default_values`  in  1  reset; synchronous, active-high, highest priority.
- `data_in`  in  1  serial data, MSB of each word first.
- `resync`  in  1  synchronous request to drop alignment; sampled every edge.
- `data_out`  out  WORD_W  last forwarded data word.
- `valid`  out  1  one-cycle strobe; `data_out` updated this cycle.
- `active`  out  1  link aligned and forwarding.
- `idle_out`  out  1  most recent aligned word was `IDLE_SYM`.

## Operation
- Shift register `sr` (`WORD_W` bits): `sr <= {sr[WORD_W-2:0], data_in}` on every edge outside reset. `word` = `{sr[WORD_W-2:0], data_in}`, the word completed at the current edge.
- Bit counter `bit_cnt`, 0..WORD_W-1, wraps to 0; `boundary` = (`bit_cnt == WORD_W-1`). COM counter `com_cnt`, width `$clog2(COM_COUNT+1)`.
- States: SEARCH, ALIGN, ACTIVE.
- SEARCH: checks `word` on every edge, at any bit offset. When `word == COM_SYM`, `bit_cnt <= 0` and `com_cnt <= 1`. The next state is ALIGN, or ACTIVE if `COM_COUNT == 1`.
- ALIGN: `bit_cnt` increments every edge. At `boundary`:
  - `word == COM_SYM`: increment `com_cnt`. Reaching `COM_COUNT` moves to ACTIVE.
  - Any other word: return to SEARCH with `com_cnt <= 0`.
  - Misaligned COM occurrences between boundaries are ignored.
- ACTIVE: `bit_cnt` keeps counting. At `boundary`:
  - `word == COM_SYM`: `valid <= 0`, `idle_out <= 0`, `data_out` holds, stay ACTIVE.
  - `word == IDLE_SYM`: `valid <= 0`, `idle_out <= 1`, `data_out` holds.
  - Any other word: `data_out <= word`, `valid <= 1`, `idle_out <= 0`.
- Off-boundary edges: `valid <= 0`; `data_out` and `idle_out` hold.
- `active` is registered: 1 exactly while the state is ACTIVE.
- `resync` = 1 in any state: next state SEARCH; `com_cnt`, `bit_cnt`, `valid`, `active` and `idle_out` go to 0; `data_out` holds. `sr` keeps shifting, so a COM completed on the following edge is detected.
- Reset: state SEARCH; `sr`, counters and all outputs go to 0. `default_values` overrides `resync`.

## Timing
- Reset values: `data_out` = 0, `valid` = 0, `active` = 0, `idle_out` = 0.
- Latency: the LSB of a word is sampled at edge E, and `data_out`/`valid`/`idle_out` reflect that word after E. That is 0 extra cycles, registered at E.
- `valid` is high at most 1 cycle in every `WORD_W`; it is never high outside ACTIVE.
- Entering ACTIVE happens at the edge sampling the LSB of the `COM_COUNT`-th COM. That COM is not forwarded, and `active` is visible after that edge.
- `resync` and `default_values` take effect at the edge where they are sampled high, including mid-word; any partial word is discarded.
- Simultaneous `resync` and COM completion in SEARCH: `resync` wins, the COM is not counted.

## Test plan
- Reset: hold `default_values` for 2 edges mid-stream → all outputs 0. No `valid` appears until 4 aligned 0xBC words are received.
- Acquire: send 3 junk bits, then 4×0xBC and 0xA5 → `active` rises after the LSB of the 4th 0xBC. Then `data_out` = 0xA5 with `valid` high for exactly 1 cycle after its 8th bit.
- Aborted alignment: 3×0xBC then 0x55 → `active` stays 0 and the block returns to SEARCH. A following 4×0xBC → `active` = 1.
- Idle/COM in ACTIVE: send 0x7C, 0xBC, 0x3C → `idle_out` = 1 with no `valid`. Then `idle_out` = 0 with no `valid`. Then `data_out` = 0x3C with `valid` and `idle_out` = 0; `active` stays 1 throughout.
- Resync mid-word in ACTIVE: pulse `resync` at bit 3 of 0x12 → `active` goes 0 at the next edge, 0x12 is never forwarded, and re-acquisition requires 4 fresh COMs.
- Generic width: `WORD_W` = 10, `COM_SYM` = 10'h17C, `IDLE_SYM` = 10'h283, `COM_COUNT` = 2, with 5-bit offset, 2×COM, then 10'h155 → `active` rises after the 2nd COM. Then `data_out` = 10'h155 with `valid` after its 10th bit.
